// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: round-robin front-end sharing one registered ALU between two requesters, one op in flight.
// Optional macro ALU_SEQ_CARRY_CHAIN_EN adds per-requester carry chaining for multi-word add/sub.
module alu_seq_ctrl #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid_i,
  output logic         req0_ready_o,
  input  logic [2:0]   req0_op_i,
  input  logic [N-1:0] req0_a_i,
  input  logic [N-1:0] req0_b_i,
  input  logic         req0_cin_i,
  input  logic         req1_valid_i,
  output logic         req1_ready_o,
  input  logic [2:0]   req1_op_i,
  input  logic [N-1:0] req1_a_i,
  input  logic [N-1:0] req1_b_i,
  input  logic         req1_cin_i,
`ifdef ALU_SEQ_CARRY_CHAIN_EN
  input  logic         req0_chain_i,
  input  logic         req1_chain_i,
`endif
  output logic [2:0]   alu_op_o,
  output logic [N-1:0] alu_a_o,
  output logic [N-1:0] alu_b_o,
  output logic         alu_cin_o,
  input  logic [N-1:0] alu_result_i,
  input  logic         alu_cout_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic         rsp_id_o,
  output logic [N-1:0] rsp_data_o,
  output logic         rsp_cout_o,
  output logic         rsp_err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_ILL = 3'b111;

  function automatic logic is_addsub(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  state_e       state_q, state_d;
  logic         rr_q, rr_d;
  logic         id_q, id_d;
  logic [2:0]   op_q, op_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic         cin_q, cin_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [N-1:0] rsp_data_q, rsp_data_d;
  logic         rsp_cout_q, rsp_cout_d;
  logic         rsp_err_q, rsp_err_d;

  logic         grant_s;
  logic         accept_s;
  logic [2:0]   sel_op_s;
  logic [N-1:0] sel_a_s;
  logic [N-1:0] sel_b_s;
  logic         sel_cin_s;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    if (req0_valid_i && req1_valid_i) begin
      grant_s = ~rr_q;
    end else if (req1_valid_i) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign accept_s     = (state_q == S_IDLE) && (req0_valid_i || req1_valid_i);
  assign req0_ready_o = accept_s && !grant_s;
  assign req1_ready_o = accept_s && grant_s;
  assign sel_op_s     = grant_s ? req1_op_i : req0_op_i;
  assign sel_a_s      = grant_s ? req1_a_i  : req0_a_i;
  assign sel_b_s      = grant_s ? req1_b_i  : req0_b_i;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  logic carry0_q, carry0_d;
  logic carry1_q, carry1_d;
  logic sel_chain_s;
  logic sel_carry_s;

  assign sel_chain_s = grant_s ? req1_chain_i : req0_chain_i;
  assign sel_carry_s = grant_s ? carry1_q : carry0_q;
  // A chained add/sub takes its carry from the requester's own carry register.
  assign sel_cin_s   = (sel_chain_s && is_addsub(sel_op_s)) ? sel_carry_s
                                                           : (grant_s ? req1_cin_i : req0_cin_i);
`else
  assign sel_cin_s   = grant_s ? req1_cin_i : req0_cin_i;
`endif

  assign alu_op_o    = op_q;
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign alu_cin_o   = cin_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_cout_o  = rsp_cout_q;
  assign rsp_err_o   = rsp_err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: illegal ops skip the ALU and go straight to the response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = (sel_op_s == OP_ILL) ? S_RESP : S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, result capture and response handshake.
  always_comb begin
    rr_d        = rr_q;
    id_d        = id_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_err_d   = rsp_err_q;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    carry0_d    = carry0_q;
    carry1_d    = carry1_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          rr_d  = grant_s;
          id_d  = grant_s;
          op_d  = sel_op_s;
          a_d   = sel_a_s;
          b_d   = sel_b_s;
          cin_d = sel_cin_s;
        end else begin
          rr_d  = rr_q;
          id_d  = id_q;
        end
        if (accept_s && (sel_op_s == OP_ILL)) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = grant_s;
          rsp_data_d  = {N{1'b0}};
          rsp_cout_d  = 1'b0;
          rsp_err_d   = 1'b1;
        end else begin
          rsp_valid_d = rsp_valid_q;
        end
      end
      S_WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_data_d  = alu_result_i;
        rsp_cout_d  = is_addsub(op_q) ? alu_cout_i : 1'b0;
        rsp_err_d   = 1'b0;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
        if (is_addsub(op_q) && !id_q) begin
          carry0_d = alu_cout_i;
        end else begin
          carry0_d = carry0_q;
        end
        if (is_addsub(op_q) && id_q) begin
          carry1_d = alu_cout_i;
        end else begin
          carry1_d = carry1_q;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_id_d    = 1'b0;
          rsp_data_d  = {N{1'b0}};
          rsp_cout_d  = 1'b0;
          rsp_err_d   = 1'b0;
        end else begin
          rsp_valid_d = rsp_valid_q;
        end
      end
      default: begin
        rsp_valid_d = rsp_valid_q;
      end
    endcase
  end

  // Datapath and response registers; reset leaves rr pointing at req1 so req0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= 1'b1;
      id_q        <= 1'b0;
      op_q        <= 3'b000;
      a_q         <= {N{1'b0}};
      b_q         <= {N{1'b0}};
      cin_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= {N{1'b0}};
      rsp_cout_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      carry0_q    <= 1'b0;
      carry1_q    <= 1'b0;
`endif
    end else begin
      rr_q        <= rr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_err_q   <= rsp_err_d;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      carry0_q    <= carry0_d;
      carry1_q    <= carry1_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural registered ALU plus a queue of expected responses.
`timescale 1ns/1ps
module tb_alu_seq_ctrl;
  localparam int N = 32;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
  localparam bit CHAIN_EN = 1'b1;
  logic req0_chain, req1_chain;
`else
  localparam bit CHAIN_EN = 1'b0;
`endif

  typedef struct packed {
    logic         id;
    logic [N-1:0] data;
    logic         cout;
    logic         err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
  logic [2:0] req0_op, req1_op, alu_op;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_data;
  logic alu_cin, alu_cout, rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  rsp_t exp_q[$];
  logic rr_m = 1'b1;
  logic [1:0] carry_m = 2'b00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op_i(req0_op),
    .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_cin_i(req0_cin),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op_i(req1_op),
    .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_cin_i(req1_cin),
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    .req0_chain_i(req0_chain), .req1_chain_i(req1_chain),
`endif
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_cin_o(alu_cin),
    .alu_result_i(alu_result), .alu_cout_i(alu_cout),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_data_o(rsp_data), .rsp_cout_o(rsp_cout), .rsp_err_o(rsp_err)
  );

  // Reference ALU; carry-out is deliberately 1 for non-arithmetic ops so masking is observable.
  function automatic logic [N:0] alu_fn(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                        input logic cin);
    case (op)
      3'b000:  return {1'b1, a};
      3'b001:  return {1'b1, ~a};
      3'b010:  return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
      3'b011:  return {1'b0, a} - {1'b0, b} - {{N{1'b0}}, cin};
      3'b100:  return {1'b1, a | b};
      3'b101:  return {1'b1, a & b};
      3'b110:  return {1'b1, {(N-1){1'b0}}, ($signed(a) < $signed(b))};
      default: return {1'b1, {N{1'b1}}};
    endcase
  endfunction

  always @(posedge clk) {alu_cout, alu_result} <= alu_fn(alu_op, alu_a, alu_b, alu_cin);

  task automatic drive(input bit id, input logic v, input logic [2:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic cin, input logic chain);
    if (id) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_cin = cin;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      req1_chain = chain;
`endif
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_cin = cin;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      req0_chain = chain;
`endif
    end
  endtask

  task automatic push_exp(input bit id, input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic cin, input logic chain);
    logic [N:0] r;
    logic eff;
    logic arith;
    arith = (op == 3'b010) || (op == 3'b011);
    eff = cin;
    if (CHAIN_EN && chain && arith) eff = carry_m[id];
    r = alu_fn(op, a, b, eff);
    if (op == 3'b111) exp_q.push_back({id, {N{1'b0}}, 1'b0, 1'b1});
    else exp_q.push_back({id, r[N-1:0], arith ? r[N] : 1'b0, 1'b0});
    if (CHAIN_EN && arith) carry_m[id] = r[N];
    rr_m = id;
  endtask

  // Presents one op and waits (bounded) for its ready; acc = cycle index of the accept edge, -1 if none.
  task automatic issue(input bit id, input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic cin, input logic chain, output int acc);
    bit found;
    found = 0;
    acc = -1;
    @(negedge clk);
    drive(id, 1'b1, op, a, b, cin, chain);
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL ready_timeout: req%0d_ready never 1 (required 1)", id);
    end else begin
      acc = cyc;
      push_exp(id, op, a, b, cin, chain);
      @(posedge clk);
    end
    #1;
    drive(id, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0);
  endtask

  // Waits (bounded) for rsp_valid, samples the response and completes the handshake.
  task automatic get_rsp(output rsp_t got, output int at, output bit ok);
    ok = 0;
    at = -1;
    got = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
    end else begin
      got = {rsp_id, rsp_data, rsp_cout, rsp_err};
      at = cyc;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err, req0_ready, req1_ready, alu_op, alu_a, alu_b, alu_cin} !== '0) begin
      failures++;
      $display("FAIL reset_in: got valid=%b data=%h op=%b a=%h required all 0", rsp_valid, rsp_data, alu_op, alu_a);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err, req0_ready, req1_ready, alu_op, alu_a, alu_b, alu_cin} !== '0) begin
      failures++;
      $display("FAIL reset_idle: got valid=%b data=%h op=%b a=%h required all 0", rsp_valid, rsp_data, alu_op, alu_a);
    end
  endtask

  task automatic test_basic_add();
    int acc, at; bit ok; rsp_t got, e;
    issue(1'b0, 3'b010, 32'd5, 32'd7, 1'b0, 1'b0, acc);
    if (acc >= 0) begin
      get_rsp(got, at, ok);
      e = exp_q.pop_front();
      if (ok) begin
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL add_rsp: got %h required %h", got, e);
        end
        checks++;
        if (at - acc !== 3) begin
          failures++;
          $display("FAIL add_latency: got %0d required 3", at - acc);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err} !== '0) begin
          failures++;
          $display("FAIL add_clear: got valid=%b data=%h required 0", rsp_valid, rsp_data);
        end
      end
    end
  endtask

  task automatic test_ops();
    int acc, at; bit ok; rsp_t got, e;
    logic [2:0] op;
    for (int k = 0; k < 6; k++) begin
      op = (k < 2) ? 3'(k) : 3'(k + 1);
      issue(1'b0, op, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc >= 0) begin
        get_rsp(got, at, ok);
        e = exp_q.pop_front();
        if (ok) begin
          checks++;
          if (got !== e || at - acc !== 3) begin
            failures++;
            $display("FAIL op%0d_rsp: got %h lat %0d required %h lat 3", op, got, at - acc, e);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc; bit ok; rsp_t got, e;
    ok = 0;
    issue(1'b1, 3'b011, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, acc);
    if (acc < 0) return;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        ok = 1;
        break;
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (!ok || cyc - acc !== 3) begin
      failures++;
      $display("FAIL bp_valid: got valid=%b lat %0d required 1 lat 3", rsp_valid, cyc - acc);
      return;
    end
    drive(1'b0, 1'b1, 3'b000, 32'h1, 32'h2, 1'b0, 1'b0);
    for (int h = 0; h < 5; h++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err} !== {1'b1, e}) begin
        failures++;
        $display("FAIL bp_hold: cycle %0d got %h required %h", h, {rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err}, {1'b1, e});
      end
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_ready: got %b%b required 00", req1_ready, req0_ready);
      end
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0);
    got = {rsp_id, rsp_data, rsp_cout, rsp_err};
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL bp_rsp: got %h required %h", got, e);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err} !== '0) begin
      failures++;
      $display("FAIL bp_clear: got valid=%b data=%h required 0", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_round_robin();
    int at; bit ok; rsp_t got, e;
    logic g;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 3'b010, 32'(k), 32'd10, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 3'b011, 32'd100, 32'(k), 1'b1, 1'b0);
      #1;
      g = ~rr_m;
      checks++;
      if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL rr_grant%0d: got ready=%b%b required grant %0d", k, req1_ready, req0_ready, g);
        drive(1'b0, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0);
        return;
      end
      if (g) push_exp(1'b1, 3'b011, 32'd100, 32'(k), 1'b1, 1'b0);
      else push_exp(1'b0, 3'b010, 32'(k), 32'd10, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0);
      get_rsp(got, at, ok);
      e = exp_q.pop_front();
      if (ok) begin
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL rr_rsp%0d: got %h required %h", k, got, e);
        end
      end
    end
  endtask

  task automatic test_illegal();
    int acc, at; bit ok; rsp_t got, e;
    issue(1'b0, 3'b111, 32'd3, 32'd4, 1'b1, 1'b0, acc);
    if (acc < 0) return;
    get_rsp(got, at, ok);
    e = exp_q.pop_front();
    if (ok) begin
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL ill_rsp: got %h required %h", got, e);
      end
      checks++;
      if (at - acc !== 1) begin
        failures++;
        $display("FAIL ill_latency: got %0d required 1", at - acc);
      end
      checks++;
      if ({alu_op, alu_a, alu_b} !== {3'b111, 32'd3, 32'd4}) begin
        failures++;
        $display("FAIL ill_opregs: got op=%b a=%h b=%h required 111 3 4", alu_op, alu_a, alu_b);
      end
    end
  endtask

  task automatic test_reset_midop();
    int acc, at; bit ok; rsp_t got, e;
    issue(1'b0, 3'b100, 32'h0F0F_0000, 32'h0000_00F0, 1'b0, 1'b0, acc);
    if (acc < 0) return;
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err, req0_ready, req1_ready, alu_op, alu_a, alu_b, alu_cin} !== '0) begin
      failures++;
      $display("FAIL midrst_out: got valid=%b op=%b a=%h required all 0", rsp_valid, alu_op, alu_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rr_m = 1'b1;
    carry_m = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_norsp: got rsp_valid=%b required 0", rsp_valid);
      end
    end
    drive(1'b0, 1'b1, 3'b100, 32'h1, 32'h2, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3'b101, 32'h3, 32'h6, 1'b0, 1'b0);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      failures++;
      $display("FAIL midrst_tie: got ready=%b%b required 01", req1_ready, req0_ready);
    end else begin
      push_exp(1'b0, 3'b100, 32'h1, 32'h2, 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0);
    if (exp_q.size() != 0) begin
      get_rsp(got, at, ok);
      e = exp_q.pop_front();
      if (ok) begin
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL midrst_rsp: got %h required %h", got, e);
        end
      end
    end
  endtask

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  task automatic test_carry_chain();
    int acc, at; bit ok; rsp_t got, e;
    logic [N-1:0] av [3] = '{32'hFFFF_FFFF, 32'd1, 32'd0};
    logic [N-1:0] bv [3] = '{32'd1, 32'd1, 32'd0};
    for (int k = 0; k < 3; k++) begin
      issue(1'(k == 1), 3'b010, av[k], bv[k], 1'(k == 1), 1'(k != 0), acc);
      if (acc >= 0) begin
        get_rsp(got, at, ok);
        e = exp_q.pop_front();
        if (ok) begin
          checks++;
          if (got !== e) begin
            failures++;
            $display("FAIL chain%0d_rsp: got %h required %h", k, got, e);
          end
        end
      end
    end
  endtask
`endif

  initial begin
    rsp_ready = 1'b0;
    drive(1'b0, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0);
    test_reset();
    test_basic_add();
    test_ops();
    test_backpressure();
    test_round_robin();
    test_illegal();
    test_reset_midop();
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    test_carry_chain();
`endif
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
